timing_decode_unit: RTL
=======================

Name: timing_decode_unit

Overview:
- Generates the inputs that the 19-bit CPU control unit consumes: the one-hot T-state timing signals from a 3-bit sequence counter, and the opcode and register-select decodes from an internally held instruction register.
- Consumes the control unit's SC_CLR and LD_IR outputs, closing the fetch/decode/execute loop.
- Sits between the common bus, where IR is loaded, and the control unit.

Parameters:
- T_LAST, 6, highest legal T-state index. The counter never exceeds it.
- IR_W, 19, instruction register width.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- BUS  in  IR_W  common bus value, captured into IR when LD_IR=1.
- LD_IR  in  1  load IR from BUS at the next edge.
- SC_CLR  in  1  clear the sequence counter at the next edge (end of instruction).
- HALT  in  1  freeze the sequence counter and IR.
- T  out  7  one-hot T-state: T[k]=1 when SC==k. Maps onto control-unit T0..T6.
- D1  out  8  one-hot decode of IR[18:16].
- D2  out  16  one-hot decode of IR[15:12], gated by D1[7]. All zero when D1[7]=0.
- Dv  out  4  one-hot decode of IR[15:14].
- Dw  out  4  one-hot decode of IR[13:12].
- Dx  out  4  one-hot decode of IR[11:10].
- Dy  out  4  one-hot decode of IR[9:8].
- Dz  out  4  one-hot decode of IR[7:6].
- IR  out  IR_W  current instruction register contents.
- INSTR_DONE  out  1  registered one-cycle pulse, the cycle after an accepted SC_CLR.
- SEQ_ERR  out  1  registered one-cycle pulse when the counter is force-wrapped from T_LAST.

Behaviour:
- State: SC[2:0], IR[18:0], INSTR_DONE, SEQ_ERR registers. All other outputs are combinational from SC and IR only, with no path from BUS, LD_IR, SC_CLR or HALT to any output.
- Reset (RST=1 at edge):
  - SC=0, so T=7'b0000001.
  - IR=0, so D1=8'h01, D2=0, and Dv=Dw=Dx=Dy=Dz=4'b0001.
  - INSTR_DONE=0, SEQ_ERR=0.
  - Reset overrides every other input, including mid-instruction.
- SC next-state, priority highest first:
  1. RST: SC=0.
  2. SC_CLR=1: SC=0 and INSTR_DONE=1 next cycle. This applies even when HALT=1.
  3. HALT=1: SC holds.
  4. SC==T_LAST: SC=0 and SEQ_ERR=1 next cycle (watchdog wrap; no instruction ends without a clear).
  5. Otherwise SC=SC+1.
- INSTR_DONE and SEQ_ERR are 0 in every cycle not caused by items 2 and 4 above. They are never both 1.
- IR update:
  - LD_IR=1 and HALT=0: IR=BUS at the edge.
  - LD_IR=1 and HALT=1: the load is dropped and IR holds.
  - LD_IR with SC_CLR in the same cycle: both take effect.
  - New decodes are visible the cycle after the load. With the control unit's LD_IR=T1, D1 and D2 are valid from T2.
- Decode rules:
  - D1[i]=1 iff IR[18:16]==i.
  - D2[j]=1 iff D1[7] and IR[15:12]==j.
  - Register selects decode unconditionally; the consumer gates them by opcode.
  - Every nonzero one-hot output has exactly one bit set.
- Latency: SC_CLR asserted in T_k gives T0 in the next cycle, so a fetch restarts with no bubble.
- T is never all-zero and never multi-hot. SC values 7..T_LAST+1 are unreachable; if reached, the next edge forces SC=0 with no SEQ_ERR.

Test Plan:
- Reset, then run free with SC_CLR=0 and HALT=0.
  - T steps 01,02,04,08,10,20,40 (hex).
  - Next cycle T=01 with SEQ_ERR=1 for one cycle.
- BUS=19'h7_3000, LD_IR pulsed while T=02 (T1).
  - The next cycle shows D1=8'h80, D2=16'h0008, Dx=Dy=Dz=4'b0001.
  - With BUS=19'h1_4000, D1=8'h02, D2=0, Dv=4'b0010, Dw=4'b0001.
- SC_CLR asserted while T=08 (T3).
  - Next cycle T=01 and INSTR_DONE=1 for exactly one cycle; SEQ_ERR stays 0.
- HALT=1 from T=04 for 3 cycles, with LD_IR=1 and BUS=19'h2_0000 during the halt.
  - T stays 04 and IR is unchanged.
  - After release, T=08.
  - HALT=1 together with SC_CLR=1 gives T=01.
- RST=1 asserted while T=20 with IR=19'h7_FFFF.
  - Next cycle T=01, IR=0, D1=8'h01, and both pulse outputs are 0.

Source files
------------

// File: rtl/timing_decode_unit.sv
// timing_decode_unit
//   Produces the timing and decode inputs of the 19-bit CPU control unit:
//   a 3-bit sequence counter (SC) presented as one-hot T-states, and one-hot
//   opcode / register-select decodes of an internally held instruction
//   register (IR). SC_CLR and LD_IR come back from the control unit.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   BUS        in   common bus, loaded into IR when LD_IR=1
//   LD_IR      in   load IR from BUS at the next edge (dropped while HALT=1)
//   SC_CLR     in   clear SC at the next edge (end of instruction)
//   HALT       in   freeze SC and IR (SC_CLR still wins)
//   T          out  one-hot T-state, T[k]=1 when SC==k
//   D1         out  one-hot decode of IR[18:16]
//   D2         out  one-hot decode of IR[15:12], zero unless D1[7]
//   Dv..Dz     out  one-hot decodes of IR[15:14], [13:12], [11:10], [9:8], [7:6]
//   IR         out  instruction register contents
//   INSTR_DONE out  one-cycle pulse the cycle after an accepted SC_CLR
//   SEQ_ERR    out  one-cycle pulse after a watchdog wrap from T_LAST
//
// All decode outputs are combinational from SC and IR only.
module timing_decode_unit #(
  parameter int T_LAST = 6,
  parameter int IR_W   = 19
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [IR_W-1:0] BUS,
  input  logic            LD_IR,
  input  logic            SC_CLR,
  input  logic            HALT,
  output logic [6:0]      T,
  output logic [7:0]      D1,
  output logic [15:0]     D2,
  output logic [3:0]      Dv,
  output logic [3:0]      Dw,
  output logic [3:0]      Dx,
  output logic [3:0]      Dy,
  output logic [3:0]      Dz,
  output logic [IR_W-1:0] IR,
  output logic            INSTR_DONE,
  output logic            SEQ_ERR
);

  localparam logic [2:0] T_LAST_SC = 3'(T_LAST);

  logic [2:0]      sc;
  logic [IR_W-1:0] ir;
  logic            instr_done;
  logic            seq_err;

  // Sequence counter, instruction register and the two status pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sc         <= 3'd0;
      ir         <= '0;
      instr_done <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      seq_err    <= 1'b0;
      if (SC_CLR) begin
        // End of instruction beats HALT so a halted CPU can still restart fetch.
        sc         <= 3'd0;
        instr_done <= 1'b1;
      end else if (HALT) begin
        sc <= sc;
      end else if (sc == T_LAST_SC) begin
        // Watchdog: an instruction ran off the end without clearing SC.
        sc      <= 3'd0;
        seq_err <= 1'b1;
      end else if (sc > T_LAST_SC) begin
        // Unreachable encodings recover silently.
        sc <= 3'd0;
      end else begin
        sc <= sc + 3'd1;
      end
      if (LD_IR && !HALT) begin
        ir <= BUS;
      end
    end
  end

  // Combinational decode of SC and IR.
  always_comb begin
    // Out-of-range SC still presents T0 so T is never all-zero.
    if (sc <= T_LAST_SC) begin
      T = 7'd1 << sc;
    end else begin
      T = 7'd1;
    end
    D1 = 8'd1 << ir[18:16];
    D2 = D1[7] ? (16'd1 << ir[15:12]) : 16'd0;
    Dv = 4'd1 << ir[15:14];
    Dw = 4'd1 << ir[13:12];
    Dx = 4'd1 << ir[11:10];
    Dy = 4'd1 << ir[9:8];
    Dz = 4'd1 << ir[7:6];
  end

  assign IR         = ir;
  assign INSTR_DONE = instr_done;
  assign SEQ_ERR    = seq_err;

endmodule
